// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential multiplier: controller states and
// the counter-width helper.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the iteration counter.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mul_if.sv
// Operand/result bundle for seq_mul: start/done handshake plus data.
interface seq_mul_if #(
  parameter int A_W = 4,
  parameter int B_W = 3
);
  logic               start;
  logic               sgn;
  logic [A_W-1:0]     a;
  logic [B_W-1:0]     b;
  logic               busy;
  logic               done;
  logic [A_W+B_W-1:0] p;

  modport master (
    output start, sgn, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_mul_addsub.sv
// W-bit adder/subtractor shared by every multiplier iteration.
// sub=1 computes x - y as x + ~y + 1; cout is the carry out of bit W-1.
module mul_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] y_eff;

  // Conditionally invert y and inject the +1 through the carry-in.
  always_comb begin
    y_eff       = sub ? ~y : y;
    {cout, s}   = {1'b0, x} + {1'b0, y_eff} + {{W{1'b0}}, sub};
  end

endmodule

// File: rtl/seq_mul.sv
// Shift-and-add multiplier: A_W x B_W product over B_W cycles, unsigned or
// two's-complement per operation, with a start/done handshake.
module seq_mul
  import mul_pkg::*;
#(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input  logic      clk,
  input  logic      rst,
  seq_mul_if.slave  bus
);

  localparam int               CNT_W = clog2(B_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(B_W - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [A_W:0]         acc_hi;
  logic [A_W:0]         a_reg;
  logic [B_W-1:0]       b_reg;
  logic                 sgn_reg;
  logic                 busy_r;
  logic                 done_r;
  logic [A_W+B_W-1:0]   p_r;

  logic                 add_en;
  logic                 last;
  logic                 do_sub;
  logic [A_W:0]         y_op;
  logic [A_W:0]         sum;
  logic                 cout;
  logic                 fill;
  logic [A_W:0]         hi_next;
  logic [B_W-1:0]       lo_next;

  mul_addsub #(
    .W(A_W + 1)
  ) u_addsub (
    .x    (acc_hi),
    .y    (y_op),
    .sub  (do_sub),
    .s    (sum),
    .cout (cout)
  );

  // One iteration: conditionally add/subtract the multiplicand, then shift
  // the {acc_hi, b_reg} pair right by one. The multiplier bit consumed each
  // cycle is shifted out of b_reg, which frees its top bit for product LSBs.
  // Signed mode keeps the true sign in sum[A_W] (A_W+1 bits never overflow);
  // unsigned mode refills with the adder carry.
  always_comb begin
    add_en  = b_reg[0];
    last    = (cnt == LAST);
    do_sub  = sgn_reg & last & add_en;
    y_op    = add_en ? a_reg : '0;
    fill    = sgn_reg ? sum[A_W] : cout;
    hi_next = {fill, sum[A_W:1]};
    lo_next = {sum[0], b_reg[B_W-1:1]};
  end

  // Controller, iteration counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sgn_reg <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      p_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_reg   <= bus.sgn ? {bus.a[A_W-1], bus.a} : {1'b0, bus.a};
            b_reg   <= bus.b;
            sgn_reg <= bus.sgn;
            acc_hi  <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= hi_next;
          b_reg  <= lo_next;
          cnt    <= cnt + 1'b1;
          if (last) begin
            p_r    <= {hi_next[A_W-1:0], lo_next};
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: 4x3 instance for handshake/timing cases and an
// 8x8 instance for wider products in both modes.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mul_if #(.A_W(4), .B_W(3)) m1 ();
  seq_mul_if #(.A_W(8), .B_W(8)) m2 ();

  seq_mul #(.A_W(4), .B_W(3)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (m1)
  );

  seq_mul #(.A_W(8), .B_W(8)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (m2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns the negedge index (counting from 'first') at which done is seen, or -1.
  task automatic wait_done1(input int first, output int n);
    n = -1;
    for (int i = first; i < first + 20; i++) begin
      @(negedge clk);
      if (m1.done) begin
        n = i;
        break;
      end
    end
  endtask

  // Issue one op on the 4x3 instance; lat = posedges from capture to done.
  task automatic op1(input logic s, input logic [3:0] a, input logic [2:0] b, output int lat);
    int n;
    m1.start = 1'b1; m1.sgn = s; m1.a = a; m1.b = b;
    @(negedge clk);
    m1.start = 1'b0;
    check("busy_run", m1.busy, 1);
    wait_done1(2, n);
    lat = (n < 0) ? -100 : n - 1;
  endtask

  // Issue one op on the 8x8 instance and compare against an integer product.
  task automatic op2(input logic s, input logic [7:0] a, input logic [7:0] b);
    int ea, eb, prod, lat;
    logic [15:0] expv;
    ea   = s ? int'($signed(a)) : int'(a);
    eb   = s ? int'($signed(b)) : int'(b);
    prod = ea * eb;
    expv = prod[15:0];
    m2.start = 1'b1; m2.sgn = s; m2.a = a; m2.b = b;
    @(negedge clk);
    m2.start = 1'b0;
    lat = -100;
    for (int i = 2; i < 30; i++) begin
      @(negedge clk);
      if (m2.done) begin
        lat = i - 1;
        break;
      end
    end
    check(s ? "w_lat_s" : "w_lat_u", lat, 8);
    check(s ? "w_p_s" : "w_p_u", m2.p, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, n, ndone;
    logic [7:0] ra, rb;

    m1.start = 1'b0; m1.sgn = 1'b0; m1.a = '0; m1.b = '0;
    m2.start = 1'b0; m2.sgn = 1'b0; m2.a = '0; m2.b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", m1.busy, 0);
    check("rst_done", m1.done, 0);
    check("rst_p", m1.p, 0);
    rst = 1'b0;
    @(negedge clk);

    // 15 x 7 unsigned
    op1(1'b0, 4'd15, 3'd7, lat);
    check("u_max_lat", lat, 3);
    check("u_max_p", m1.p, 7'd105);
    @(negedge clk);
    check("done_one_cycle", m1.done, 0);
    check("idle_busy", m1.busy, 0);
    check("p_held", m1.p, 7'd105);

    // -8 x -4 signed
    op1(1'b1, 4'b1000, 3'b100, lat);
    check("s_nn_lat", lat, 3);
    check("s_nn_p", m1.p, 7'b0100000);
    @(negedge clk);

    // 7 x -1 signed
    op1(1'b1, 4'd7, 3'b111, lat);
    check("s_mix_p", m1.p, 7'b1111001);
    @(negedge clk);

    // start pulse with different operands during RUN is ignored
    m1.start = 1'b1; m1.sgn = 1'b0; m1.a = 4'd3; m1.b = 3'd5;
    @(negedge clk);
    m1.start = 1'b0;
    @(negedge clk);
    m1.start = 1'b1; m1.a = 4'd1; m1.b = 3'd1;
    @(negedge clk);
    m1.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m1.done) ndone++;
    end
    check("ign_done_cnt", ndone, 1);
    check("ign_p", m1.p, 7'd15);

    // reset during iteration 1 aborts the operation
    m1.start = 1'b1; m1.sgn = 1'b0; m1.a = 4'd7; m1.b = 3'd7;
    @(negedge clk);
    m1.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", m1.busy, 0);
    check("abort_done", m1.done, 0);
    check("abort_p", m1.p, 0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m1.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    op1(1'b0, 4'd3, 3'd2, lat);
    check("after_abort_lat", lat, 3);
    check("after_abort_p", m1.p, 7'd6);
    @(negedge clk);

    // back-to-back: start held through DONE
    m1.start = 1'b1; m1.sgn = 1'b0; m1.a = 4'd2; m1.b = 3'd3;
    wait_done1(1, n);
    check("b2b_lat1", n - 1, 3);
    check("b2b_p1", m1.p, 7'd6);
    check("b2b_busy_done", m1.busy, 0);
    m1.a = 4'd5; m1.b = 3'd5;
    @(negedge clk);
    m1.start = 1'b0;
    check("b2b_restart_busy", m1.busy, 1);
    wait_done1(2, n);
    check("b2b_gap", n, 4);
    check("b2b_p2", m1.p, 7'd25);
    @(negedge clk);

    // 8x8 corners and random operands in both modes
    op2(1'b0, 8'd255, 8'd255);
    @(negedge clk);
    op2(1'b1, 8'h80, 8'h80);
    @(negedge clk);
    op2(1'b1, 8'h80, 8'h7f);
    @(negedge clk);
    op2(1'b1, 8'hff, 8'h01);
    @(negedge clk);
    op2(1'b0, 8'd0, 8'd200);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op2(i[0], ra, rb);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
